// File: rtl/rv32_hazard_ctl.sv
// Hazard, forwarding and flush controller beside the decode stage of the RV32 pipeline.
// A shifting scoreboard of post-decode destinations drives forwarding selects, load-use stalls and redirect flushes.
module rv32_hazard_ctl #(
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned NREG       = 32,
   parameter int unsigned LOAD_STAGE = 1,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned RA_W      = $clog2(NREG),
   localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_wen,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   output logic             stall,
   output logic             issue,
   output logic             flush_if,
   output logic             flush_id,
   output logic [SEL_W-1:0] fwd_a_sel,
   output logic [SEL_W-1:0] fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [DEPTH-1:0] v_q, v_d;
   logic [DEPTH-1:0] ld_q, ld_d;
   logic [RA_W-1:0]  rd_q [DEPTH];
   logic [RA_W-1:0]  rd_d [DEPTH];

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [SEL_W-1:0] sel_a, sel_b;
   logic             haz_a, haz_b;

   // Walk oldest to youngest so the youngest matching entry is the last to assign.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int unsigned k = DEPTH; k > 0; k--) begin
         if (v_q[k-1] && (rd_q[k-1] == id_rs1) && (id_rs1 != '0) && id_rs1_used) begin
            sel_a = SEL_W'(k);
            haz_a = ld_q[k-1] && ((k - 1) < LOAD_STAGE);
         end
         if (v_q[k-1] && (rd_q[k-1] == id_rs2) && (id_rs2 != '0) && id_rs2_used) begin
            sel_b = SEL_W'(k);
            haz_b = ld_q[k-1] && ((k - 1) < LOAD_STAGE);
         end
      end
   end

   always_comb begin
      stall     = id_valid && (haz_a || haz_b) && !ex_redirect;
      issue     = id_valid && !stall && !ex_redirect;
      flush_if  = ex_redirect;
      flush_id  = ex_redirect;
      fwd_a_sel = id_valid ? sel_a : '0;
      fwd_b_sel = id_valid ? sel_b : '0;
   end

   // Entry 0 takes the issuing instruction or a bubble; older entries shift unconditionally.
   always_comb begin
      v_d     = '0;
      ld_d    = '0;
      rd_d    = rd_q;
      v_d[0]  = issue && id_wen && (id_rd != '0);
      rd_d[0] = id_rd;
      ld_d[0] = id_is_load;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         v_d[i]  = v_q[i-1];
         rd_d[i] = rd_q[i-1];
         ld_d[i] = ld_q[i-1];
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ex_redirect && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q         <= '0;
         ld_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         v_q         <= v_d;
         ld_q        <= ld_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      rd_q <= rd_d;
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
